// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver and the shift-register transmitters.
// Holds the FSM state encoding and the line levels of the frame format.
package sipo_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rxState_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits, stop bit,
// delivered through a registered valid/ready holding register.
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             ferr,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  rxState_t         state;
  rxState_t         nextState;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             lastBit;

  assign lastBit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    if (LSB_FIRST) shifted = {sin, sreg[WIDTH-1:1]};
    else           shifted = {sreg[WIDTH-2:0], sin};
  end

  always_comb begin
    nextState = state;
    if (en) begin
      case (state)
        IDLE:    if (sin == START_BIT) nextState = DATA;
        DATA:    if (lastBit) nextState = STOP;
        STOP:    nextState = (sin == STOP_BIT) ? IDLE : BREAK;
        BREAK:   if (sin == IDLE_LEVEL) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // busy is registered from the next state so it tracks the current state exactly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      dout    <= '0;
      dvalid  <= 1'b0;
      ferr    <= 1'b0;
      overrun <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nextState;
      busy    <= (nextState != IDLE);
      ferr    <= 1'b0;
      overrun <= 1'b0;
      if (dvalid && dready) dvalid <= 1'b0;
      if (en) begin
        case (state)
          IDLE: if (sin == START_BIT) cnt <= '0;
          DATA: begin
            sreg <= shifted;
            if (!lastBit) cnt <= cnt + 1'b1;
          end
          STOP: begin
            if (sin == STOP_BIT) begin
              if (!dvalid || dready) begin
                dout   <= sreg;
                dvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              ferr <= 1'b1;
              sreg <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed and randomized frames checked
// against a frame-level reference model, with an MSB-first twin sharing the stimulus.
module tb_sipo_frame_rx;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       sin;
  logic       dready;
  logic [7:0] dout;
  logic       dvalid;
  logic       ferr;
  logic       overrun;
  logic       busy;
  logic [7:0] dout2;
  logic       dvalid2;
  logic       ferr2;
  logic       overrun2;
  logic       busy2;

  int checks;
  int failures;

  logic [7:0] expDout;
  logic       expValid;
  logic       expFerr;
  logic       expOvr;

  sipo_frame_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sin(sin), .dout(dout), .dvalid(dvalid),
    .dready(dready), .ferr(ferr), .overrun(overrun), .busy(busy)
  );

  sipo_frame_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dutMsb (
    .clk(clk), .rstn(rstn), .en(en), .sin(sin), .dout(dout2), .dvalid(dvalid2),
    .dready(dready), .ferr(ferr2), .overrun(overrun2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input logic expBusy);
    chk("dvalid", {7'd0, dvalid}, {7'd0, expValid});
    chk("dout", dout, expDout);
    chk("ferr", {7'd0, ferr}, {7'd0, expFerr});
    chk("overrun", {7'd0, overrun}, {7'd0, expOvr});
    chk("busy", {7'd0, busy}, {7'd0, expBusy});
    chk("dout_msb", dout2, rev8(expDout));
    chk("dvalid_msb", {7'd0, dvalid2}, {7'd0, expValid});
  endtask

  // kind: 0 = no stop sample, 1 = good stop sample of word, 2 = bad stop sample
  task automatic step(input logic e, input logic s, input logic r, input int kind,
                      input logic [7:0] word, input logic busyAfter);
    @(negedge clk);
    en = e; sin = s; dready = r;
    expFerr = 1'b0;
    expOvr  = 1'b0;
    if (kind == 1) begin
      if (!expValid || r) begin
        expDout  = word;
        expValid = 1'b1;
      end else begin
        expOvr = 1'b1;
      end
    end else begin
      if (kind == 2) expFerr = 1'b1;
      if (expValid && r) expValid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkAll(busyAfter);
  endtask

  task automatic strobe(input logic s, input logic r, input logic busyAfter, input int gap);
    step(1'b1, s, r, 0, 8'h00, busyAfter);
    for (int g = 1; g < gap; g++) step(1'b0, 1'($urandom), r, 0, 8'h00, busyAfter);
  endtask

  task automatic sendFrame(input logic [7:0] word, input logic stopBit, input int gap,
                           input logic rDuring, input logic rStop);
    strobe(1'b0, rDuring, 1'b1, gap);
    for (int i = 0; i < 8; i++) strobe(word[i], rDuring, 1'b1, gap);
    step(1'b1, stopBit, rStop, stopBit ? 1 : 2, word, !stopBit);
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b1, r, 0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    checks = 0; failures = 0;
    expDout = '0; expValid = 1'b0; expFerr = 1'b0; expOvr = 1'b0;
    rstn = 1'b0; en = 1'b0; sin = 1'b1; dready = 1'b0;

    #2;
    checkAll(1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idleCycles(2, 1'b0);

    // basic frame, continuous strobes, LSB-first and MSB-first views
    sendFrame(8'hA5, 1'b1, 1, 1'b0, 1'b0);
    idleCycles(1, 1'b1);
    sendFrame(8'h01, 1'b1, 1, 1'b0, 1'b0);
    idleCycles(2, 1'b1);

    // sparse strobes with glitches between them
    sendFrame(8'h3C, 1'b1, 4, 1'b0, 1'b0);
    idleCycles(2, 1'b1);

    // framing error, held-low break, recovery
    sendFrame(8'hFF, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0, 1'b1, 2);
    strobe(1'b1, 1'b0, 1'b0, 1);
    idleCycles(2, 1'b0);
    sendFrame(8'h12, 1'b1, 1, 1'b0, 1'b0);
    idleCycles(1, 1'b1);

    // overrun with consumer stalled, then drain
    sendFrame(8'h11, 1'b1, 1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1, 1'b0, 1'b0);
    idleCycles(3, 1'b0);
    idleCycles(2, 1'b1);

    // consume and deliver on the same edge
    sendFrame(8'h11, 1'b1, 1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1, 1'b0, 1'b1);
    idleCycles(1, 1'b0);
    idleCycles(2, 1'b1);

    // asynchronous reset mid-frame
    strobe(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 1'b0, 1'b1, 1);
    @(negedge clk);
    en = 1'b0; sin = 1'b1;
    #3 rstn = 1'b0;
    expDout = '0; expValid = 1'b0; expFerr = 1'b0; expOvr = 1'b0;
    #1;
    checkAll(1'b0);
    @(negedge clk);
    rstn = 1'b1;
    idleCycles(2, 1'b0);
    sendFrame(8'h5A, 1'b1, 1, 1'b0, 1'b0);
    idleCycles(2, 1'b1);

    // randomized frames, gaps, stop bits and consumer readiness
    for (int f = 0; f < 12; f++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        sendFrame(w, 1'b0, $urandom_range(1, 3), 1'($urandom), 1'($urandom));
        strobe(1'b1, 1'($urandom), 1'b0, 1);
      end else begin
        sendFrame(w, 1'b1, $urandom_range(1, 3), 1'($urandom), 1'($urandom));
      end
      idleCycles($urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-in/parallel-out frame receiver; the receive end of the team's parallel-load shift-register transmitters, which shift LSB first.
- Samples a serial line on bit strobes, detects start bit, shifts in WIDTH data bits, checks stop bit.
- Presents the assembled word on a registered valid/ready output port.
- Sits between the serial link and the byte consumer (counter/register datapath).

Parameters:
- WIDTH, 8, data bits per frame (legal 2..16)
- LSB_FIRST, 1, 1 = first data bit received lands in dout[0]; 0 = first bit lands in dout[WIDTH-1]

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- en  input  1  bit strobe; line sampled only on clk edges where en=1
- sin  input  1  serial line, idle high
- dout  output  WIDTH  received word (holding register)
- dvalid  output  1  dout holds an unconsumed word
- dready  input  1  consumer accepts dout when dvalid&&dready
- ferr  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous on rstn=0. It forces state=IDLE, sreg=0, bit counter=0, dout=0, dvalid=0, ferr=0, overrun=0, busy=0.
- Reset mid-frame discards the partial word; after release, reception resumes at the next start bit.
- No state change on edges with en=0, except the handshake clear of dvalid and the return of pulse outputs to 0.
- FSM states: IDLE, DATA, STOP, BREAK.
  - IDLE: en&&sin=0 -> DATA, cnt=0. en&&sin=1 -> stay.
  - DATA: en -> shift sin into sreg and increment cnt. When cnt==WIDTH-1, go to STOP instead of incrementing.
  - STOP, en&&sin=1: deliver the word (see below), then go to IDLE.
  - STOP, en&&sin=0: pulse ferr, discard sreg, go to BREAK.
  - BREAK: en&&sin=1 -> IDLE. Otherwise stay. This prevents a held-low line being re-read as a start bit.
- Shift direction:
  - LSB_FIRST=1: sreg <= {sin, sreg[WIDTH-1:1]}.
  - LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], sin}.
- Bit counter width is clog2(WIDTH). The counter never wraps within a frame.
- Delivery happens on the edge that samples the stop bit:
  - If dvalid=0, or dvalid&&dready in that same cycle: dout<=sreg and dvalid<=1. A simultaneous consume and deliver keeps dvalid=1 with the new data and raises no overrun.
  - If dvalid=1 and dready=0: dout unchanged, new word dropped, overrun pulses for 1 cycle.
- Handshake:
  - dvalid falls on the edge after dvalid&&dready unless a delivery occurs on that edge.
  - dout is stable while dvalid=1 and dready=0.
  - dready while dvalid=0 has no effect.
- Latency: dvalid is high in the cycle immediately after the stop-bit sampling edge. With en=1 every cycle, a frame occupies WIDTH+2 edges.
- ferr and overrun are mutually exclusive and registered, each high for exactly 1 cycle.
- busy is registered from state.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, DATA=2'd1, STOP=2'd2, BREAK=2'd3
  - the frame-format constants: start=0, stop=1, idle=1
- The transmitter-side shift registers reuse the same package.
- Single module. The bit counter is the only natural sub-module candidate, named frame_bit_cnt. Keep it inline unless the transmitter also needs it.

Test Plan:
- Reset, then en=1 every cycle, sin frame 0,(1,0,1,0,0,1,0,1),1 -> dout=8'hA5, dvalid=1 one cycle after stop edge, ferr=0, busy low again. With LSB_FIRST=0 the same bits give dout=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 8'h01 -> 8'h80.
- en high every 4th cycle, sin changes only between strobes, byte 8'h3C -> dout=8'h3C after 10 strobes. Glitches on sin between strobes are ignored.
- Stop bit 0 on byte 8'hFF -> ferr 1-cycle pulse, dvalid stays 0, busy stays 1 (BREAK). Hold sin=0 for 5 strobes -> no new frame. sin=1 strobe -> IDLE. Next frame 8'h12 received correctly.
- dready=0, two back-to-back frames 8'h11 then 8'h22 -> dout stays 8'h11, overrun pulses at second stop edge. Then dready=1 -> dvalid falls next edge.
- dvalid=1 (8'h11) and dready=1 asserted exactly on the stop edge of 8'h22 -> dout=8'h22, dvalid stays 1, overrun=0.
- Assert rstn=0 asynchronously (not on a clk edge) after 4 data bits -> all outputs 0 immediately. Release, send 8'h5A -> dout=8'h5A with no corruption from the partial frame.
